// File: rtl/led_frame_scheduler_if.sv
// Bundle between the LED frame scheduler and its surroundings: the two
// frame sources, the pixel serializer handshake and the status outputs.
interface led_frame_scheduler_if #(
  parameter int NUM_LEDS_W = 12
);
  // Source side
  logic [1:0]            req;
  logic [23:0]           grb0;
  logic [23:0]           grb1;
  logic [NUM_LEDS_W-1:0] len0;
  logic [NUM_LEDS_W-1:0] len1;
  logic [1:0]            gnt;
  logic [1:0]            frame_done;

  // Serializer side
  logic                  pix_valid;
  logic [23:0]           pix_grb;
  logic                  pix_ready;
  logic                  ser_busy;
  logic [NUM_LEDS_W-1:0] led_index;

  // Status
  logic                  busy;

  // Environment driving requests and serializer responses
  modport master (
    output req, grb0, grb1, len0, len1, pix_ready, ser_busy,
    input  gnt, frame_done, pix_valid, pix_grb, led_index, busy
  );

  // The scheduler itself
  modport slave (
    input  req, grb0, grb1, len0, len1, pix_ready, ser_busy,
    output gnt, frame_done, pix_valid, pix_grb, led_index, busy
  );
endinterface

// File: rtl/led_frame_scheduler.sv
// LED frame scheduler: round-robin arbitration between two frame sources,
// streams one colour to len pixels through a valid/ready serializer port,
// waits for the serializer to finish shifting, then holds the strip latch
// time before reporting the frame complete.
//
// state | meaning
// IDLE  | no frame; grant a requester (not in the frame_done cycle)
// LOAD  | capture colour and length of the granted source
// SEND  | offer pixels, advance led_index on each handshake
// DRAIN | wait for the serializer to stop shifting
// LATCH | hold the line low for LATCH_CYCLES, then pulse frame_done
module led_frame_scheduler #(
  parameter int NUM_LEDS_W   = 12,
  parameter int LATCH_CYCLES = 15000
) (
  input logic                  clk,
  input logic                  reset,
  led_frame_scheduler_if.slave bus
);

  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    DRAIN,
    LATCH
  } state_t;

  state_t                state;
  logic                  src;        // index of the source owning the frame
  logic                  last_gnt;   // index of the source served last
  logic [NUM_LEDS_W-1:0] len_q;
  logic [CNT_W-1:0]      latch_cnt;

  logic                  grant_src;
  logic [23:0]           grb_sel;
  logic [NUM_LEDS_W-1:0] len_sel;
  logic                  last_pixel;

  // Round-robin pick: a lone requester wins; on a tie the source not
  // served last wins. Source selection for LOAD follows the grant.
  always_comb begin
    grant_src = bus.req[1];
    if (bus.req == 2'b11) begin
      grant_src = ~last_gnt;
    end
    grb_sel    = src ? bus.grb1 : bus.grb0;
    len_sel    = src ? bus.len1 : bus.len0;
    last_pixel = (bus.led_index == (len_q - NUM_LEDS_W'(1)));
  end

  // Frame sequencing FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      src            <= 1'b0;
      last_gnt       <= 1'b1;
      len_q          <= '0;
      latch_cnt      <= '0;
      bus.gnt        <= '0;
      bus.frame_done <= '0;
      bus.pix_valid  <= 1'b0;
      bus.pix_grb    <= '0;
      bus.led_index  <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.frame_done <= '0;
      case (state)
        IDLE: begin
          // The frame_done cycle is skipped so a fresh request is only
          // looked at once the previous frame is fully closed.
          if ((bus.req != 2'b00) && (bus.frame_done == 2'b00)) begin
            src      <= grant_src;
            bus.gnt  <= grant_src ? 2'b10 : 2'b01;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          len_q         <= len_sel;
          bus.led_index <= '0;
          if (len_sel == '0) begin
            bus.frame_done <= bus.gnt;
            bus.gnt        <= '0;
            last_gnt       <= src;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end else begin
            bus.pix_grb   <= grb_sel;
            bus.pix_valid <= 1'b1;
            state         <= SEND;
          end
        end

        SEND: begin
          if (bus.pix_valid && bus.pix_ready) begin
            if (last_pixel) begin
              bus.pix_valid <= 1'b0;
              state         <= DRAIN;
            end else begin
              bus.led_index <= bus.led_index + NUM_LEDS_W'(1);
            end
          end
        end

        DRAIN: begin
          if (!bus.ser_busy) begin
            latch_cnt <= LATCH_LOAD;
            state     <= LATCH;
          end
        end

        LATCH: begin
          if (latch_cnt == '0) begin
            bus.frame_done <= bus.gnt;
            bus.gnt        <= '0;
            last_gnt       <= src;
            bus.busy       <= 1'b0;
            bus.pix_grb    <= '0;
            bus.led_index  <= '0;
            state          <= IDLE;
          end else begin
            latch_cnt <= latch_cnt - CNT_W'(1);
          end
        end

        default: begin
          state         <= IDLE;
          bus.gnt       <= '0;
          bus.pix_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

  // A completion pulse never coincides with a pixel offer, and the grant
  // is always one-hot or empty.
  a_done_excl : assert property (@(posedge clk) disable iff (reset)
    !(bus.pix_valid && (bus.frame_done != 2'b00)));
  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.gnt));

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: stimulus pushes the expected frame
// (source, colour, length) into a queue when a request is raised; a
// negedge monitor pops it on each new grant and checks grant, pixels,
// latch duration and the completion pulse.
module tb_led_frame_scheduler;

  localparam int W     = 12;
  localparam int LATCH = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  led_frame_scheduler_if #(.NUM_LEDS_W(W)) bus ();

  led_frame_scheduler #(
    .NUM_LEDS_W  (W),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          src;
    logic [23:0] grb;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  int     checks = 0;
  int     errors = 0;
  bit     model_last = 1'b1;
  int     ready_mode = 0;

  function automatic logic [1:0] oh(input bit s);
    return s ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Serializer model: pix_ready pattern and ser_busy lingering 1..3 cycles
  // after each accepted pixel. Driven just after the rising edge.
  initial begin
    int bcnt;
    bit hs;
    bcnt = 0;
    bus.pix_ready = 1'b0;
    bus.ser_busy  = 1'b0;
    forever begin
      @(posedge clk);
      hs = bus.pix_valid && bus.pix_ready;
      #1;
      if (hs) bcnt = $urandom_range(1, 3);
      else if (bcnt > 0) bcnt--;
      bus.ser_busy = (bcnt != 0);
      case (ready_mode)
        0:       bus.pix_ready = ($urandom_range(0, 9) < 6);
        1:       bus.pix_ready = 1'b1;
        default: bus.pix_ready = ~bus.pix_ready;
      endcase
    end
  end

  // Monitor / scoreboard.
  bit         active = 0;
  int         idx, cyc, phase, lat;
  bit         first_pix;
  logic [1:0] prev_gnt = 2'b00;

  always @(negedge clk) begin
    if (reset) begin
      active   = 0;
      prev_gnt = 2'b00;
    end else begin
      chk("done_valid_excl", 32'(bus.pix_valid && (bus.frame_done != 2'b00)), 32'd0);
      if (prev_gnt == 2'b00 && bus.gnt != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected gnt=%b required none", bus.gnt);
        end else begin
          cur = exp_q.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(oh(cur.src)));
          active    = 1;
          idx       = 0;
          cyc       = 0;
          phase     = 0;
          lat       = 0;
          first_pix = 0;
        end
      end else if (active) begin
        cyc++;
      end

      if (!active) begin
        chk("idle_quiet", 32'({bus.frame_done, bus.pix_valid}), 32'd0);
      end else if (bus.frame_done != 2'b00) begin
        chk("frame_done_src", 32'(bus.frame_done), 32'(oh(cur.src)));
        chk("handshake_count", 32'(idx), 32'(cur.len));
        chk("gnt_clear_at_done", 32'(bus.gnt), 32'd0);
        chk("busy_low_at_done", 32'(bus.busy), 32'd0);
        if (cur.len == 0) chk("zero_len_done_cycle", 32'(cyc), 32'd1);
        else              chk("latch_cycles", 32'(lat), 32'(LATCH));
        active = 0;
      end else begin
        chk("gnt_held", 32'(bus.gnt), 32'(oh(cur.src)));
        chk("busy_high", 32'(bus.busy), 32'd1);
        if (cur.len != 0 && cyc >= 1) chk("pix_grb_hold", 32'(bus.pix_grb), 32'(cur.grb));
        if (phase == 2) lat++;
        else if (phase == 1 && !bus.ser_busy) begin
          phase = 2;
          lat   = 0;
        end
        if (cur.len == 0 || phase != 0) begin
          chk("pix_valid_low", 32'(bus.pix_valid), 32'd0);
        end else if (bus.pix_valid) begin
          if (!first_pix) begin
            first_pix = 1;
            chk("first_pix_cycle", 32'(cyc), 32'd1);
          end
          chk("led_index", 32'(bus.led_index), 32'(idx));
          if (bus.pix_ready) begin
            idx++;
            if (idx == cur.len) phase = 1;
          end
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  // One frame: predict the grant, raise req, optionally drop req or
  // disturb the source inputs after capture, then wait for completion.
  task automatic run_frame(input logic [1:0] r, input logic [23:0] g0, input logic [23:0] g1,
                           input int l0, input int l1, input bit drop_req, input int mutate,
                           output bit ok);
    frame_t f;
    f.src = (r == 2'b11) ? ~model_last : r[1];
    f.grb = f.src ? g1 : g0;
    f.len = f.src ? l1 : l0;
    exp_q.push_back(f);
    model_last = f.src;
    bus.grb0 = g0;
    bus.grb1 = g1;
    bus.len0 = W'(l0);
    bus.len1 = W'(l1);
    bus.req  = r;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout gnt=%b required=%b", bus.gnt, oh(f.src));
      return;
    end
    @(negedge clk);
    if (drop_req) bus.req = 2'b00;
    if (mutate == 1) begin
      bus.grb0 = 24'($urandom);
      bus.grb1 = 24'($urandom);
      bus.len0 = W'($urandom_range(0, 15));
      bus.len1 = W'($urandom_range(0, 15));
    end else if (mutate == 2) begin
      bus.grb0 = 24'hFF0000;
    end
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.frame_done != 2'b00) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout frame_done=%b required=%b", bus.frame_done, oh(f.src));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_gnt"},        32'(bus.gnt),        32'd0);
    chk({tag, "_pix_valid"},  32'(bus.pix_valid),  32'd0);
    chk({tag, "_pix_grb"},    32'(bus.pix_grb),    32'd0);
    chk({tag, "_led_index"},  32'(bus.led_index),  32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
  endtask

  initial begin
    bit ok;
    frame_t f;
    bus.req  = 2'b00;
    bus.grb0 = '0;
    bus.grb1 = '0;
    bus.len0 = '0;
    bus.len1 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic frame, always-ready serializer.
    ready_mode = 1;
    run_frame(2'b01, 24'h00FF00, 24'h123456, 3, 7, 1, 0, ok);
    bus.req = 2'b00;
    ready_mode = 0;
    // Zero length on source 1.
    if (ok) run_frame(2'b10, 24'hABCDEF, 24'h0F0F0F, 5, 0, 1, 0, ok);
    bus.req = 2'b00;
    // Colour change after capture is ignored.
    if (ok) run_frame(2'b01, 24'h0000FF, 24'h111111, 6, 2, 0, 2, ok);
    bus.req = 2'b00;
    // Backpressure with alternating ready.
    ready_mode = 2;
    if (ok) run_frame(2'b01, 24'h5A5A5A, 24'h222222, 4, 1, 1, 0, ok);
    bus.req = 2'b00;
    ready_mode = 0;

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      if (!ok) break;
      if ($urandom_range(0, 1) == 1) begin
        bus.req = 2'b00;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      ready_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_frame(2'($urandom_range(1, 3)), 24'($urandom), 24'($urandom),
                $urandom_range(0, 9), $urandom_range(0, 9),
                1'($urandom_range(0, 1)), $urandom_range(0, 1), ok);
    end
    bus.req = 2'b00;
    ready_mode = 0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a 10-pixel frame.
    if (ok) begin
      f.src = (2'b01 == 2'b11) ? 1'b0 : 1'b0;
      f.grb = 24'($urandom);
      f.len = 10;
      exp_q.push_back(f);
      bus.grb0 = f.grb;
      bus.len0 = W'(10);
      bus.req  = 2'b01;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (bus.pix_valid && bus.led_index == W'(5)) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL reach_index5 led_index=%0d required=5", bus.led_index);
      end else begin
        #2 reset = 1'b1;
        #1 chk_outputs_zero("async_reset");
        exp_q.delete();
        model_last = 1'b1;
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        chk("no_done_in_reset", 32'(bus.frame_done), 32'd0);
        reset = 1'b0;
      end
    end

    // Tie held after reset: grants alternate starting with source 0.
    for (int k = 0; k < 4; k++) begin
      if (!ok) break;
      run_frame(2'b11, 24'h0A0B0C, 24'h0C0B0A, 2, 2, 0, 0, ok);
    end
    bus.req = 2'b00;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
